// File: rtl/ervp_serial_link_arbiter.sv
// Shares one serial request/response link among NUM_REQ requesters, one transaction in flight.
// Define ERVP_SLINK_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins); default is round-robin.
module ervp_serial_link_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BW_REQ  = 4,
    parameter int BW_RESP = 8,
    parameter int BW_IDX  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rstnn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BW_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [BW_RESP-1:0]        resp_data,
    input  logic                      link_ready,
    output logic                      link_start,
    output logic [BW_REQ-1:0]         link_req_data,
    input  logic [BW_RESP-1:0]        link_resp_data,
    output logic                      busy,
    output logic [BW_IDX-1:0]         grant_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESPOND
    } state_t;

    state_t               r_state;
    logic [BW_IDX-1:0]    r_grant;
    logic [BW_REQ-1:0]    r_req;
    logic [BW_RESP-1:0]   r_resp;
    logic                 r_link_start;
    logic [NUM_REQ-1:0]   r_resp_valid;

    logic                 w_any;
    logic [BW_IDX-1:0]    w_win;
    logic                 w_accept;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [BW_IDX-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (idx == BW_IDX'(i));
        end
        return v;
    endfunction

`ifdef ERVP_SLINK_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_any = |req_valid;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_win = BW_IDX'(k);
            end
        end
    end
`else
    logic [BW_IDX-1:0] r_rr;

    // Scan from the rr pointer upward, wrapping past NUM_REQ-1; first hit wins.
    always_comb begin
        logic [BW_IDX:0] pos;
        w_any = 1'b0;
        w_win = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, r_rr} + (BW_IDX+1)'(k);
            if (pos >= (BW_IDX+1)'(NUM_REQ)) begin
                pos = pos - (BW_IDX+1)'(NUM_REQ);
            end
            if (!w_any && req_valid[pos[BW_IDX-1:0]]) begin
                w_any = 1'b1;
                w_win = pos[BW_IDX-1:0];
            end
        end
    end
`endif

    assign w_accept = (r_state == S_IDLE) && w_any && link_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_win == BW_IDX'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_req        <= '0;
            r_resp       <= '0;
            r_link_start <= 1'b0;
            r_resp_valid <= '0;
`ifndef ERVP_SLINK_ARB_FIXED_PRIORITY_EN
            r_rr         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_win;
                        r_req        <= req_data[int'(w_win)*BW_REQ +: BW_REQ];
                        r_link_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (link_ready) begin
                        r_link_start <= 1'b0;
                        r_state      <= S_WAIT_BUSY;
                    end
                end
                // The link master drops ready one cycle after taking start.
                S_WAIT_BUSY: begin
                    if (!link_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (link_ready) begin
                        r_resp       <= link_resp_data;
                        r_resp_valid <= f_onehot(r_grant);
                        r_state      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (resp_ready[r_grant]) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
`ifndef ERVP_SLINK_ARB_FIXED_PRIORITY_EN
                        r_rr         <= (r_grant == BW_IDX'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign link_start    = r_link_start;
    assign link_req_data = r_req;
    assign resp_valid    = r_resp_valid;
    assign resp_data     = r_resp;
    assign grant_idx     = r_grant;

endmodule

// File: tb/tb_ervp_serial_link_arbiter.sv
// Directed bench for ervp_serial_link_arbiter with a transaction-level model checked every cycle.
module tb_ervp_serial_link_arbiter;
    localparam int N  = 4;
    localparam int BR = 4;
    localparam int BS = 8;
    localparam int BI = 2;

    logic            clk = 1'b0;
    logic            rstnn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*BR-1:0] req_data = 16'h4A21;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [BS-1:0]   resp_data;
    logic            link_ready;
    logic            link_start;
    logic [BR-1:0]   link_req_data;
    logic [BS-1:0]   link_resp_data;
    logic            busy;
    logic [BI-1:0]   grant_idx;

    always #5 clk = ~clk;

    ervp_serial_link_arbiter #(.NUM_REQ(N), .BW_REQ(BR), .BW_RESP(BS)) dut (
        .clk(clk), .rstnn(rstnn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .link_ready(link_ready), .link_start(link_start),
        .link_req_data(link_req_data), .link_resp_data(link_resp_data),
        .busy(busy), .grant_idx(grant_idx)
    );

    // Link master model: busy for busy_cycles after taking a start; response derived from request.
    logic          l_ready;
    int            l_cnt;
    logic [BS-1:0] l_resp;
    logic          force_busy = 1'b0;
    int            busy_cycles = 6;

    assign link_ready     = l_ready && !force_busy;
    assign link_resp_data = l_ready ? l_resp : 8'h00;

    always @(posedge clk) begin
        if (!rstnn) begin
            l_ready <= 1'b1;
            l_cnt   <= 0;
            l_resp  <= '0;
        end else if (link_ready && link_start) begin
            l_ready <= 1'b0;
            l_cnt   <= busy_cycles;
            l_resp  <= {link_req_data ^ 4'hF, link_req_data ^ 4'h6};
        end else if (!l_ready) begin
            if (l_cnt <= 1) l_ready <= 1'b1;
            else            l_cnt   <= l_cnt - 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int rr);
`ifdef ERVP_SLINK_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    // Transaction-level model state
    logic          m_inflight = 1'b0;
    logic          m_start = 1'b0;
    logic          m_seen_busy = 1'b0;
    logic          m_rv = 1'b0;
    int            m_rr = 0;
    int            m_g = 0;
    logic [BR-1:0] m_req = '0;
    logic [BS-1:0] m_resp = '0;

    int            acc_cyc[$];
    int            acc_g[$];
    logic [BR-1:0] start_d[$];
    int            rv_cyc[$];
    logic [BS-1:0] rv_data[$];
    logic          prev_ls = 1'b0;
    logic          prev_rv = 1'b0;

    always @(negedge clk) begin : mon
        int w;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_rv;
        if (mon_en) begin
            w = winner(req_valid, m_rr);
            exp_rr = (!m_inflight && link_ready && w >= 0) ? (4'(1) << w) : 4'(0);
            exp_rv = m_rv ? (4'(1) << m_g) : 4'(0);
            chk("req_ready", 32'(req_ready), 32'(exp_rr));
            chk("busy", 32'(busy), 32'(m_inflight));
            chk("link_start", 32'(link_start), 32'(m_inflight && m_start));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("resp_data", 32'(resp_data), 32'(m_resp));
            chk("link_req_data", 32'(link_req_data), 32'(m_req));
            chk("grant_idx", 32'(grant_idx), 32'(m_g));

            if (req_ready != '0) begin
                acc_cyc.push_back(cyc);
                for (int i = 0; i < N; i++) if (req_ready[i]) acc_g.push_back(i);
            end
            if (link_start && !prev_ls) start_d.push_back(link_req_data);
            if (resp_valid != '0 && !prev_rv) begin
                rv_cyc.push_back(cyc);
                rv_data.push_back(resp_data);
            end
            prev_ls = rstnn && link_start;
            prev_rv = rstnn && (resp_valid != '0);

            if (!rstnn) begin
                m_inflight = 1'b0; m_start = 1'b0; m_seen_busy = 1'b0; m_rv = 1'b0;
                m_rr = 0; m_g = 0; m_req = '0; m_resp = '0;
            end else if (!m_inflight) begin
                if (exp_rr != '0) begin
                    m_inflight = 1'b1; m_g = w; m_req = req_data[w*BR +: BR];
                    m_start = 1'b1; m_seen_busy = 1'b0; m_rv = 1'b0;
                end
            end else if (m_start) begin
                if (link_ready) m_start = 1'b0;
            end else if (!m_rv) begin
                if (!link_ready) m_seen_busy = 1'b1;
                else if (m_seen_busy) begin
                    m_rv = 1'b1;
                    m_resp = link_resp_data;
                end
            end else if (resp_ready[m_g]) begin
                m_inflight = 1'b0;
                m_rv = 1'b0;
                m_rr = (m_g + 1) % N;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (acc_g.size() >= target) begin ok = 1'b1; break; end
            tick(1);
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_rv(input int target, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rv_data.size() >= target) begin ok = 1'b1; break; end
            tick(1);
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rstnn = 1'b0;
        tick(1);
        rstnn = 1'b1;
    endtask

    initial begin : stim
        int base;
        int rbase;
        int rel_cyc;
        int exp_g[5];
        logic [BS-1:0] held;

        rstnn = 1'b0;
        tick(1);
        mon_en = 1'b1;
        tick(1);
        rstnn = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_link_req_data", 32'(link_req_data), 32'd0);
        chk("rst_link_start", 32'(link_start), 32'd0);

        // Single request on lane 2 (data A -> link returns 5C after 6 busy cycles)
        resp_ready = 4'hF;
        req_valid = 4'b0100;
        wait_acc(1, "t1_accept_timeout");
        tick(1);
        req_valid = '0;
        wait_rv(1, "t1_resp_timeout");
        chk("t1_grant_lane", 32'(acc_g[0]), 32'd2);
        chk("t1_start_data", 32'(start_d[0]), 32'hA);
        chk("t1_resp_data", 32'(rv_data[0]), 32'h5C);
        chk("t1_latency", 32'(rv_cyc[0] - acc_cyc[0]), 32'd9);
        tick(2);
        chk("t1_grant_idx", 32'(grant_idx), 32'd2);

        // All four valid continuously
        do_reset();
        base = acc_g.size();
        rbase = rv_data.size();
        req_valid = 4'hF;
        wait_acc(base + 5, "t2_accept_timeout");
        req_valid = '0;
        wait_rv(rbase + 5, "t2_resp_timeout");
`ifdef ERVP_SLINK_ARB_FIXED_PRIORITY_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) chk("t2_grant_order", 32'(acc_g[base + i]), 32'(exp_g[i]));
        chk("t2_back_to_back", 32'(acc_cyc[base + 1] - rv_cyc[rbase]), 32'd1);
        chk("t2_resp_lane1_or_0", 32'(rv_data[rbase + 1]),
            (exp_g[1] == 1) ? 32'hD4 : 32'hE7);
        tick(2);

        // link_ready low in IDLE blocks acceptance
        base = acc_g.size();
        force_busy = 1'b1;
        req_valid = 4'b0010;
        tick(6);
        chk("t3_no_accept", 32'(acc_g.size()), 32'(base));
        force_busy = 1'b0;
        rel_cyc = cyc;
        wait_acc(base + 1, "t3_accept_timeout");
        chk("t3_accept_cycle", 32'(acc_cyc[base]), 32'(rel_cyc));
        chk("t3_grant", 32'(acc_g[base]), 32'd1);
        tick(1);
        req_valid = '0;
        wait_rv(rv_data.size() >= 1 ? rv_data.size() + 0 : 1, "t3_dummy_wait");
        tick(12);

        // Response held while the granted requester stalls
        base = acc_g.size();
        rbase = rv_data.size();
        resp_ready = 4'b1101;
        req_valid = 4'b0010;
        wait_acc(base + 1, "t4_accept_timeout");
        tick(1);
        req_valid = 4'b1101;
        wait_rv(rbase + 1, "t4_resp_timeout");
        chk("t4_resp_data", 32'(rv_data[rbase]), 32'hD4);
        held = resp_data;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 32'(resp_valid), 32'b0010);
            chk("t4_hold_data", 32'(resp_data), 32'(held));
            tick(1);
        end
        chk("t4_no_new_grant", 32'(acc_g.size()), 32'(base + 1));
        req_valid = '0;
        resp_ready = 4'hF;
        tick(3);
        chk("t4_released", 32'(busy), 32'd0);

        // Reset during WAIT_DONE
        base = acc_g.size();
        rbase = rv_data.size();
        req_valid = 4'b0010;
        wait_acc(base + 1, "t5_accept_timeout");
        tick(1);
        req_valid = '0;
        for (int i = 0; i < 20 && link_ready; i++) tick(1);
        chk("t5_link_busy", 32'(link_ready), 32'd0);
        tick(2);
        rstnn = 1'b0;
        tick(1);
        rstnn = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_resp_valid", 32'(resp_valid), 32'd0);
        chk("t5_link_start", 32'(link_start), 32'd0);
        chk("t5_grant_idx", 32'(grant_idx), 32'd0);
        chk("t5_link_req_data", 32'(link_req_data), 32'd0);
        chk("t5_resp_data", 32'(resp_data), 32'd0);
        tick(10);
        chk("t5_discarded", 32'(rv_data.size()), 32'(rbase));
        req_valid = 4'b0110;
        wait_acc(base + 2, "t5_accept2_timeout");
        chk("t5_grant_after_reset", 32'(acc_g[base + 1]), 32'd1);
        tick(1);
        req_valid = '0;
        wait_rv(rbase + 1, "t5_resp_timeout");
        chk("t5_resp_after_reset", 32'(rv_data[rbase]), 32'hD4);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
